// File: rtl/vce_palette_loader.sv
// Streams a palette from a source memory into VCE colour RAM through the
// VCE register port: sets the CRAM index once, then writes each entry as lo/hi bytes.
module vce_palette_loader #(
    parameter int         ENTRIES    = 512,
    parameter logic [8:0] START_ADDR = 9'h000
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       bus_en,
    input  logic       start,
    input  logic       abort,
    output logic [8:0] pal_addr,
    input  logic [8:0] pal_data,
    output logic [2:0] A,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic       CS_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SET_LO, S_SET_HI, S_FETCH, S_WR_LO, S_WR_HI, S_FINISH
    } state_t;

    localparam logic [9:0] ENTRIES_W = 10'(ENTRIES);

    state_t     state_q, state_d;
    logic       phase_q, phase_d;   // bus states: 0 = ASSERT, 1 = RECOVER; FETCH: 0 = address out, 1 = data in
    logic [9:0] count_q, count_d;
    logic [8:0] lat_q, lat_d;
    logic [8:0] pal_addr_q, pal_addr_d;
    logic [2:0] a_q, a_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       aborted_q, aborted_d;
    logic       asserting;

    function automatic logic is_bus(input state_t s);
        return (s == S_SET_LO) || (s == S_SET_HI) || (s == S_WR_LO) || (s == S_WR_HI);
    endfunction

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        count_d    = count_q;
        lat_d      = lat_q;
        pal_addr_d = pal_addr_q;
        aborted_d  = aborted_q;
        a_d        = a_q;
        dout_d     = dout_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    aborted_d = 1'b0;
                    count_d   = 10'd0;
                    state_d   = S_SET_LO;
                    phase_d   = 1'b0;
                end
            end
            S_SET_LO, S_SET_HI, S_WR_LO, S_WR_HI: begin
                if (bus_en) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        case (state_q)
                            S_SET_LO: state_d = S_SET_HI;
                            S_SET_HI: begin
                                state_d    = S_FETCH;
                                pal_addr_d = START_ADDR + count_q[8:0];
                            end
                            S_WR_LO:  state_d = S_WR_HI;
                            default: begin
                                // CTA auto-increments on each hi-byte write, so no re-addressing.
                                count_d = count_q + 10'd1;
                                if (count_d < ENTRIES_W) begin
                                    state_d    = S_FETCH;
                                    pal_addr_d = START_ADDR + count_d[8:0];
                                end else begin
                                    state_d = S_FINISH;
                                end
                            end
                        endcase
                    end
                end
            end
            S_FETCH: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    lat_d   = pal_data;
                    state_d = S_WR_LO;
                    phase_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            phase_d   = 1'b0;
            aborted_d = 1'b1;
        end

        // A and D_out move only when a new ASSERT phase begins.
        if (is_bus(state_d) && (state_d != state_q)) begin
            case (state_d)
                S_SET_LO: begin a_d = 3'd2; dout_d = START_ADDR[7:0];        end
                S_SET_HI: begin a_d = 3'd3; dout_d = {7'b0, START_ADDR[8]};  end
                S_WR_LO:  begin a_d = 3'd4; dout_d = lat_d[7:0];             end
                default:  begin a_d = 3'd5; dout_d = {7'b0, lat_d[8]};       end
            endcase
        end

        asserting = is_bus(state_d) && !phase_d;
        cs_n_d    = !asserting;
        wr_n_d    = !asserting;
        doe_d     = asserting;
        busy_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d    = (state_d == S_FINISH);
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            count_q    <= 10'd0;
            lat_q      <= 9'd0;
            pal_addr_q <= 9'd0;
            a_q        <= 3'd0;
            dout_q     <= 8'd0;
            doe_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
            pal_addr_q <= pal_addr_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign pal_addr    = pal_addr_q;
    assign A           = a_q;
    assign D_out       = dout_q;
    assign D_oe        = doe_q;
    assign CS_n        = cs_n_q;
    assign WR_n        = wr_n_q;
    assign RD_n        = 1'b1;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/vce_palette_loader.md
VCE_PALETTE_LOADER -- requirements
Module: vce_palette_loader

Interface
REQ-001 Parameter ENTRIES, default 512, is the number of palette entries written per load (1..512).
REQ-002 Parameter START_ADDR, default 9'h000, is the first CRAM index written.
REQ-003 Port clock, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset_N, input, 1: reset; synchronous, active-low.
REQ-005 Port bus_en, input, 1: CPU/MMIO-rate clock enable, the same enable that paces the VCE register port.
REQ-006 Port start, input, 1: single-cycle request to begin a load.
REQ-007 Port abort, input, 1: cancel an in-progress load.
REQ-008 Port pal_addr, output, 9: palette source memory read address.
REQ-009 Port pal_data, input, 9: source entry {G[2:0],R[2:0],B[2:0]}, valid one clock after pal_addr.
REQ-010 Port A, output, 3: VCE register select.
REQ-011 Port D_out, output, 8: write data; D_oe, output, 1: data drive enable (top ties to the tristate D bus).
REQ-012 Port CS_n, WR_n, RD_n, outputs, 1 each: active-low VCE strobes; RD_n SHALL be constant 1.
REQ-013 Ports busy, output, 1 (load in progress); done, output, 1 (one-clock completion pulse); aborted, output, 1 (sticky until next start).

Function
REQ-014 All outputs SHALL be registered.
REQ-015 States: IDLE, SET_LO, SET_HI, FETCH, WR_LO, WR_HI, FINISH.
REQ-016 Each bus state (SET_LO, SET_HI, WR_LO, WR_HI) SHALL have two phases. ASSERT: CS_n=0, WR_n=0, D_oe=1, A/D_out stable. RECOVER: CS_n=1, WR_n=1, D_oe=0, A/D_out held.
REQ-017 ASSERT SHALL advance to RECOVER on the first clock with bus_en=1; RECOVER SHALL advance to the next state on the next clock with bus_en=1. WR_n is therefore low for exactly one bus_en tick and high for at least one tick between writes.
REQ-018 IDLE: on start=1 with abort=0, clear aborted, set busy, enter SET_LO/ASSERT on the next clock.
REQ-019 SET_LO: A=2, D_out=START_ADDR[7:0]. SET_HI: A=3, D_out={7'b0,START_ADDR[8]}.
REQ-020 FETCH: drive pal_addr=index, wait exactly one clock, latch pal_data, enter WR_LO. No bus strobes are asserted during FETCH.
REQ-021 WR_LO: A=4, D_out=latched[7:0]. WR_HI: A=5, D_out={7'b0,latched[8]}.
REQ-022 After WR_HI, the 10-bit entry counter SHALL increment. The block SHALL return to FETCH if the count is below ENTRIES, else enter FINISH. The CRAM address is not rewritten, because the VCE auto-increments CTA on an A=5 write.
REQ-023 pal_addr SHALL be (START_ADDR+count) mod 512, so loads wrap from 511 to 0.
REQ-024 FINISH: pulse done=1 for one clock, clear busy, return to IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL, on the next clock, set CS_n=WR_n=1, D_oe=0, busy=0, aborted=1, and return to IDLE; done SHALL NOT pulse.
REQ-027 abort and start together in IDLE: abort wins; the block stays IDLE with aborted unchanged.
REQ-028 With bus_en constantly 1, timing SHALL be:
- each bus state: 2 clocks;
- the two address-setup writes: 4 clocks;
- each entry: 6 clocks (2 FETCH + 4).
REQ-029 D_out and A SHALL change only on entry to an ASSERT phase.

Reset
REQ-030 On reset_N=0 at a clock edge:
- state=IDLE, count=0;
- CS_n=1, WR_n=1, RD_n=1;
- A=0, D_out=0, D_oe=0, pal_addr=0;
- busy=0, done=0, aborted=0.
REQ-031 Reset mid-load SHALL take priority over all inputs and deassert the strobes on that same edge.

Verification
REQ-032 ENTRIES=2, START_ADDR=0, bus_en=1, source {9'h1A5, 9'h0FF}, start -> bus writes in order (A,D): (2,00),(3,00),(4,A5),(5,01),(4,FF),(5,00); done pulses once.
REQ-033 bus_en high 1 clock in 7, one entry -> each WR_n low pulse spans exactly one bus_en-high clock, and WR_n is high across at least one bus_en-high clock between writes.
REQ-034 START_ADDR=9'h1FF, ENTRIES=2 -> SET_HI D_out=01; pal_addr sequence 1FF then 000.
REQ-035 abort during WR_LO/ASSERT -> next clock CS_n=WR_n=1, busy=0, aborted=1, no done; a following start clears aborted and restarts from SET_LO.
REQ-036 start pulsed again mid-load -> ignored; total write count stays 2+2*ENTRIES.
REQ-037 reset_N=0 during WR_HI/ASSERT -> next clock all outputs at REQ-030 values.
